vec_lane_sequencer: RTL and testbench

- Upstream/downstream wrapper for the combinational vector ALU. It issues one 16-bit half-precision lane pair per cycle and collects lane results into a 256-bit result register.
- For VDOT it alternates multiply and add issues to build a scalar dot-product accumulator.
- Sits between the decode/register-read stage and writeback. It owns the ALU's operand and opcode inputs and is the sole consumer of its result.

---
 rtl/vec_lane_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_vec_lane_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
// vec_lane_sequencer: per-lane issue/collect wrapper around the vector ALU.
// Optional build macro LANE_MASK_EN adds a per-lane enable mask.
module vec_lane_sequencer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                opcode,
    input  logic [LANES*LANE_W-1:0]   vec_a,
    input  logic [LANES*LANE_W-1:0]   vec_b,
`ifdef LANE_MASK_EN
    input  logic [LANES-1:0]          lane_mask,
`endif
    output logic [LANES*LANE_W-1:0]   alu_op_1,
    output logic [LANES*LANE_W-1:0]   alu_op_2,
    output logic [3:0]                alu_opcode,
    input  logic [LANES*LANE_W-1:0]   alu_result,
    output logic                      busy,
    output logic                      done,
    output logic [LANES*LANE_W-1:0]   result
);

    localparam int W  = LANES * LANE_W;
    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE, S_LANE, S_DMUL, S_DADD, S_PASS, S_DONE
    } state_t;

    state_t state, state_n;

    logic [3:0]        op_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [IW-1:0]     idx;
    logic [LANE_W-1:0] acc;
    logic [LANE_W-1:0] prod;
    logic [W-1:0]      result_q;
    logic [LANES-1:0]  lane_en;
    logic [IW-1:0]     first_idx;
    logic [IW-1:0]     next_idx;
    logic              next_any;

    logic [LANE_W-1:0] a_lane;
    logic [LANE_W-1:0] b_lane;
    logic [LANE_W-1:0] res_lane;

    assign a_lane   = a_q[idx*LANE_W +: LANE_W];
    assign b_lane   = (op_q == OP_SMUL) ? b_q[LANE_W-1:0]
                                        : b_q[idx*LANE_W +: LANE_W];
    assign res_lane = alu_result[LANE_W-1:0];
    assign result   = result_q;

`ifdef LANE_MASK_EN
    logic [LANES-1:0] mask_q;
    assign lane_en = mask_q;

    // First enabled lane of the incoming mask; 0 if none is enabled.
    always_comb begin
        first_idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_mask[k]) first_idx = k[IW-1:0];
        end
    end
`else
    assign lane_en   = '1;
    assign first_idx = '0;
`endif

    // Next enabled lane above the current one, for VDOT lane skipping.
    always_comb begin
        next_idx = '0;
        next_any = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!next_any && k > int'(idx) && lane_en[k]) begin
                next_idx = k[IW-1:0];
                next_any = 1'b1;
            end
        end
    end

    assign busy = (state == S_LANE) || (state == S_DMUL) ||
                  (state == S_DADD) || (state == S_PASS);
    assign done = (state == S_DONE);

    // Next-state and ALU drive.
    always_comb begin
        state_n    = state;
        alu_op_1   = '0;
        alu_op_2   = '0;
        alu_opcode = OP_NOP;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_VADD || opcode == OP_SMUL)
                        state_n = S_LANE;
                    else if (opcode == OP_VDOT)
                        state_n = S_DMUL;
                    else
                        state_n = S_PASS;
                end
            end
            S_LANE: begin
                alu_op_1[LANE_W-1:0] = a_lane;
                alu_op_2[LANE_W-1:0] = b_lane;
                alu_opcode           = op_q;
                state_n = (idx == LAST) ? S_DONE : S_LANE;
            end
            S_DMUL: begin
                // Only reached on a disabled lane when no lane is enabled.
                if (lane_en[idx]) begin
                    alu_op_1[LANE_W-1:0] = a_lane;
                    alu_op_2[LANE_W-1:0] = b_lane;
                    alu_opcode           = OP_VDOT;
                    state_n              = S_DADD;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DADD: begin
                alu_op_1[LANE_W-1:0] = acc;
                alu_op_2[LANE_W-1:0] = prod;
                alu_opcode           = OP_VADD;
                state_n = next_any ? S_DMUL : S_DONE;
            end
            S_PASS: begin
                alu_op_1   = a_q;
                alu_op_2   = b_q;
                alu_opcode = op_q;
                state_n    = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, operand latches, lane counter and result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            acc      <= '0;
            prod     <= '0;
            result_q <= '0;
`ifdef LANE_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= opcode;
                        a_q  <= vec_a;
                        b_q  <= vec_b;
                        acc  <= '0;
                        prod <= '0;
                        idx  <= (opcode == OP_VDOT) ? first_idx : '0;
`ifdef LANE_MASK_EN
                        mask_q <= lane_mask;
`endif
                    end
                end
                S_LANE: begin
                    result_q[idx*LANE_W +: LANE_W] <=
                        lane_en[idx] ? res_lane : a_lane;
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                S_DMUL: begin
                    if (lane_en[idx]) begin
                        prod <= res_lane;
                    end else begin
                        result_q <= {{(W-LANE_W){1'b0}}, acc};
                        idx      <= '0;
                    end
                end
                S_DADD: begin
                    acc <= res_lane;
                    if (next_any) begin
                        idx <= next_idx;
                    end else begin
                        result_q <= {{(W-LANE_W){1'b0}}, res_lane};
                        idx      <= '0;
                    end
                end
                S_PASS: result_q <= alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// tb_vec_lane_sequencer: scoreboard bench with a behavioural fp16 ALU.
// Build with +define+LANE_MASK_EN to exercise the lane mask.
module tb_vec_lane_sequencer;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int W      = LANES * LANE_W;
    localparam int TMO    = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] vec_a;
    logic [W-1:0] vec_b;
    logic [W-1:0] alu_op_1;
    logic [W-1:0] alu_op_2;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_result;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef LANE_MASK_EN
    logic [LANES-1:0] lane_mask;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           nbusy;
    } exp_t;

    exp_t sb[$];

    vec_lane_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .vec_a      (vec_a),
        .vec_b      (vec_b),
`ifdef LANE_MASK_EN
        .lane_mask  (lane_mask),
`endif
        .alu_op_1   (alu_op_1),
        .alu_op_2   (alu_op_2),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        r = 1.0 + real'(int'(h[9:0])) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return r;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real r;
        int  e;
        int  m;
        if (x <= 0.0) return 16'h0000;
        r = x;
        e = 15;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m = int'((r - 1.0) * 1024.0);
        return {1'b0, e[4:0], m[9:0]};
    endfunction

    // Behavioural ALU: fp16 add/mul on lane 0, integer add otherwise.
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            4'b0000: alu_result[15:0] =
                r2h(h2r(alu_op_1[15:0]) + h2r(alu_op_2[15:0]));
            4'b0001,
            4'b0010: alu_result[15:0] =
                r2h(h2r(alu_op_1[15:0]) * h2r(alu_op_2[15:0]));
            4'b1111: alu_result = '0;
            default: alu_result = alu_op_1 + alu_op_2;
        endcase
    end

    task automatic chk(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op; the expectation is queued, then popped on done.
    task automatic run_op(input string        name,
                          input logic [3:0]   op,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [15:0]  m,
                          input logic [W-1:0] er,
                          input int           el,
                          input int           eb,
                          input bit           poke);
        exp_t e;
        int   n;
        int   nb;
        bit   seen;
        sb.push_back('{er, el, eb});
        opcode = op;
        vec_a  = a;
        vec_b  = b;
`ifdef LANE_MASK_EN
        lane_mask = m[LANES-1:0];
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = poke;
        if (poke) vec_a = ~a;
        n    = 1;
        nb   = 0;
        seen = 1'b0;
        while (!seen && n < TMO) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(posedge clk); #1;
                n++;
            end
        end
        if (!seen) begin
            chk({name, "_done_seen"}, W'(done), W'(1));
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({name, "_result"}, result, e.res);
            chk({name, "_latency"}, W'(n), W'(e.lat));
            chk({name, "_busy_cycles"}, W'(nb), W'(e.nbusy));
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_done_pulse"}, W'(done), W'(0));
        chk({name, "_idle_after"}, W'(busy), W'(0));
        chk({name, "_result_hold"}, result, er);
    endtask

    initial begin
        int ndone;
        rst    = 1'b1;
        start  = 1'b0;
        opcode = 4'b0000;
        vec_a  = '0;
        vec_b  = '0;
`ifdef LANE_MASK_EN
        lane_mask = '1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, '0);
        chk("rst_opcode", W'(alu_opcode), W'(4'b1111));
        chk("rst_op1", alu_op_1, '0);
        chk("rst_op2", alu_op_2, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("vadd", 4'b0000, {16{16'h3C00}}, {16{16'h4000}},
               16'hFFFF, {16{16'h4200}}, 17, 16, 1'b0);

        run_op("smul", 4'b0010, {16{16'h4000}},
               {{15{16'hFFFF}}, 16'h3800},
               16'hFFFF, {16{16'h3C00}}, 17, 16, 1'b0);

        run_op("vdot", 4'b0001, {16{16'h4000}}, {16{16'h4000}},
               16'hFFFF, {240'd0, 16'h5400}, 33, 32, 1'b0);

        run_op("pass", 4'b1000, W'(16'h10), W'(16'h20),
               16'hFFFF, W'(16'h30), 2, 1, 1'b1);

`ifdef LANE_MASK_EN
        run_op("mdot3", 4'b0001, {16{16'h4000}}, {16{16'h4000}},
               16'h0003, {240'd0, 16'h4800}, 5, 4, 1'b0);
        run_op("mdot0", 4'b0001, {16{16'h4000}}, {16{16'h4000}},
               16'h0000, '0, 2, 1, 1'b0);
        run_op("madd", 4'b0000, {16{16'h3C00}}, {16{16'h4000}},
               16'h00FF, {{8{16'h3C00}}, {8{16'h4200}}}, 17, 16, 1'b0);
        lane_mask = '1;
`endif

        // Abort a VDOT with reset in cycle 5.
        opcode = 4'b0001;
        vec_a  = {16{16'h4000}};
        vec_b  = {16{16'h4000}};
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_result", result, '0);
        chk("abort_opcode", W'(alu_opcode), W'(4'b1111));
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("abort_no_done", W'(ndone), W'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
